seg7_readback_decoder: RTL and testbench
========================================

# seg7_readback_decoder

Decodes the multiplexed, active-low 7-segment bus driven by the countdown display back into digit codes and a binary value. It closes the loop on the display path of the traffic-light controller. It sits beside the display drivers, samples the segment and digit-select lines, and filters scan glitches with a per-digit stability counter. It publishes a debounced two-digit reading (units, tens) with an update strobe for self-check logic and the testbench.

## Interface
- STABLE_CYCLES, 4, consecutive matching selected samples required to commit a digit; legal range ≥1
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- SEG  in  7  active-low segments, bit0=a … bit6=g
- DIG  in  2  active-high digit select: DIG[0]=units, DIG[1]=tens
- NUM_UNITS  out  5  committed units code: 0–9, 31=OFF (blank), 30=ILLEGAL
- NUM_TENS  out  5  committed tens code, same encoding
- VALUE  out  7  tens*10+units in binary; 127 when not representable
- valid  out  1  level: both digits committed, units 0–9, tens 0–9 or OFF
- update  out  1  one-cycle pulse when VALUE/valid are refreshed after a commit that changed a digit
- err  out  1  sticky: ILLEGAL committed or DIG==2'b11 sampled; cleared only by reset

## Operation
- Input stage: SEG and DIG are registered once at every edge, with no exceptions.
- Decode from the registered SEG:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9, 1111111→31.
  - Any other pattern decodes to 30.
- Sample ownership: a registered sample belongs to a digit only when DIG is exactly its one-hot bit.
  - DIG 00: both trackers hold.
  - DIG 11: both trackers hold, and err is set.
- Per-digit tracker FSM:
  - **EMPTY**: any owned sample loads the candidate, sets count=1, and moves to TRACK. When STABLE_CYCLES=1 it commits immediately and moves to LOCKED.
  - **TRACK**: an owned sample equal to the candidate increments count. When count reaches STABLE_CYCLES, the candidate is copied to NUM_x and the tracker moves to LOCKED. An owned sample that differs reloads the candidate with count=1.
  - **LOCKED**: an owned sample equal to NUM_x stays. A differing sample loads the candidate, count=1, moves to TRACK, and NUM_x holds its old value.
- Counter rules: width is $clog2(STABLE_CYCLES+1) and it saturates. Non-owned cycles never reset it.
- Commit effects: a commit whose value differs from the previous NUM_x raises a pending flag. The pending flag recomputes VALUE and valid and pulses update.
  - A commit of an identical value does nothing.
  - Tens OFF counts as 0 for VALUE.
  - Units OFF, or any ILLEGAL digit, gives VALUE=127 and valid=0.
  - Committing code 30 sets err.
- Simultaneous commits: units and tens can never commit on the same edge, because ownership is exclusive.

## Timing
- Reset values:
  - NUM_UNITS=NUM_TENS=31.
  - VALUE=0, valid=0, update=0, err=0.
  - Trackers in EMPTY with count=0; input registers 7'h7F and 2'b00.
- Latency: pattern and DIG held from edge k.
  - Edge k: input register captures.
  - Edge k+STABLE_CYCLES: NUM_x updates.
  - Edge k+STABLE_CYCLES+1: VALUE, valid and the update pulse.
- update is high for exactly one cycle per changing commit.
- reset_n assertion mid-operation returns every register to its reset value immediately, with no clock required. Release is synchronous to the next edge; the integrating top provides release timing.

## Structure
- Package seg7_pkg holds:
  - The ten digit patterns plus SEG_OFF=7'h7F.
  - NUM_OFF=5'd31 and NUM_ILLEGAL=5'd30.
  - A decode function, pattern→5-bit code.
- Sub-module seg7_digit_tracker holds the FSM, candidate, counter and commit output. It is instantiated twice (units, tens) with an owned-sample enable.
- The top holds the input registers, the decoder, the VALUE/valid/update/err logic and the output registers.

## Test plan
- After reset, with SEG=1111111 and DIG=00 idle: all outputs stay at reset values for 20 cycles.
- Alternate DIG 01/10 each cycle with units "7" (1111000) and tens "2" (0100100), STABLE_CYCLES=4:
  - NUM_UNITS=7 and NUM_TENS=2.
  - One update pulse per changing commit.
  - Final VALUE=27 with valid=1.
- Units held at "3" for 3 owned samples, then 1 sample of "8", then "3" again:
  - No commit until 4 consecutive "3" samples.
  - NUM_UNITS stays unchanged during the glitch.
- Units committed at 5, then tens pattern 1111111: NUM_TENS=31, VALUE=5, valid=1.
- Units pattern 1010101 held for 4 owned samples: NUM_UNITS=30, VALUE=127, valid=0, err=1 and sticky.
- DIG=11 for one cycle:
  - err=1.
  - No tracker count changes.
  - Assert reset_n low mid-TRACK: all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/seg7_readback_decoder_pkg.sv
// Shared constants, tracker state type and segment decode for the 7-segment readback path.
// Segment patterns are active-low, bit0=a ... bit6=g.
package seg7_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned NUM_W  = 5;
    localparam int unsigned DIG_W  = 2;
    localparam int unsigned VAL_W  = 7;

    localparam logic [SEG_W-1:0] SEG_0   = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1   = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2   = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3   = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4   = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5   = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6   = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7   = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8   = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9   = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    localparam logic [NUM_W-1:0] NUM_OFF     = 5'd31;
    localparam logic [NUM_W-1:0] NUM_ILLEGAL = 5'd30;

    localparam logic [VAL_W-1:0] VALUE_BAD = 7'd127;

    typedef enum logic [1:0] {
        TRK_EMPTY  = 2'd0,
        TRK_TRACK  = 2'd1,
        TRK_LOCKED = 2'd2
    } trk_state_e;

    // Maps a segment pattern to 0-9, NUM_OFF for blank, NUM_ILLEGAL otherwise.
    function automatic logic [NUM_W-1:0] seg7_decode(input logic [SEG_W-1:0] seg);
        logic [NUM_W-1:0] code;
        case (seg)
            SEG_0:   code = 5'd0;
            SEG_1:   code = 5'd1;
            SEG_2:   code = 5'd2;
            SEG_3:   code = 5'd3;
            SEG_4:   code = 5'd4;
            SEG_5:   code = 5'd5;
            SEG_6:   code = 5'd6;
            SEG_7:   code = 5'd7;
            SEG_8:   code = 5'd8;
            SEG_9:   code = 5'd9;
            SEG_OFF: code = NUM_OFF;
            default: code = NUM_ILLEGAL;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg7_readback_decoder_if.sv
// Display bus as seen by the readback decoder: sampled segment/digit lines in, decoded reading out.
interface seg7_readback_decoder_if;
    import seg7_pkg::*;

    logic [SEG_W-1:0] SEG;
    logic [DIG_W-1:0] DIG;
    logic [NUM_W-1:0] NUM_UNITS;
    logic [NUM_W-1:0] NUM_TENS;
    logic [VAL_W-1:0] VALUE;
    logic             valid;
    logic             update;
    logic             err;

    modport master (
        output SEG, DIG,
        input  NUM_UNITS, NUM_TENS, VALUE, valid, update, err
    );

    modport slave (
        input  SEG, DIG,
        output NUM_UNITS, NUM_TENS, VALUE, valid, update, err
    );
endinterface

// File: rtl/seg7_readback_decoder_tracker.sv
// Per-digit stability tracker: commits a code after STABLE_CYCLES consecutive matching owned samples.
module seg7_digit_tracker
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_own,
    input  logic [NUM_W-1:0] i_code,
    output logic [NUM_W-1:0] o_num,
    output logic             o_chg,
    output logic             o_done
);

    localparam int unsigned    CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  C_STABLE = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]  C_ONE    = CW'(1);
    localparam bit             ONE_SHOT = (STABLE_CYCLES == 1);

    trk_state_e       r_state;
    logic [NUM_W-1:0] r_cand;
    logic [CW-1:0]    r_cnt;
    logic [NUM_W-1:0] r_num;
    logic             r_chg;
    logic             r_done;

    logic [CW-1:0]    w_cnt_inc;
    logic             w_load;
    logic             w_commit;
    logic [NUM_W-1:0] w_commit_val;

    // A load restarts the candidate; a commit copies it to the published code.
    assign w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + C_ONE;
    assign w_load       = (r_state == TRK_EMPTY) ||
                          ((r_state == TRK_TRACK)  && (i_code != r_cand)) ||
                          ((r_state == TRK_LOCKED) && (i_code != r_num));
    assign w_commit     = i_own && ((w_load && ONE_SHOT) ||
                          ((r_state == TRK_TRACK) && (i_code == r_cand) && (w_cnt_inc >= C_STABLE)));
    assign w_commit_val = w_load ? i_code : r_cand;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= TRK_EMPTY;
            r_cand  <= NUM_OFF;
            r_cnt   <= '0;
            r_num   <= NUM_OFF;
            r_chg   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_chg <= 1'b0;
            if (i_own) begin
                if (w_load) begin
                    r_cand  <= i_code;
                    r_cnt   <= C_ONE;
                    r_state <= TRK_TRACK;
                end else if (r_state == TRK_TRACK) begin
                    r_cnt <= w_cnt_inc;
                end
                if (w_commit) begin
                    r_num   <= w_commit_val;
                    r_chg   <= (w_commit_val != r_num);
                    r_done  <= 1'b1;
                    r_state <= TRK_LOCKED;
                end
            end
        end
    end

    assign o_num  = r_num;
    assign o_chg  = r_chg;
    assign o_done = r_done;

endmodule

// File: rtl/seg7_readback_decoder.sv
// Samples the multiplexed active-low 7-segment bus and publishes a debounced two-digit reading.
module seg7_readback_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    seg7_readback_decoder_if.slave bus
);

    logic [SEG_W-1:0] r_seg;
    logic [DIG_W-1:0] r_dig;
    logic [VAL_W-1:0] r_value;
    logic             r_valid;
    logic             r_update;
    logic             r_err;

    logic [NUM_W-1:0] w_code;
    logic [NUM_W-1:0] w_num_u;
    logic [NUM_W-1:0] w_num_t;
    logic             w_chg_u;
    logic             w_chg_t;
    logic             w_done_u;
    logic             w_done_t;
    logic             w_units_ok;
    logic             w_tens_ok;
    logic [VAL_W-1:0] w_tens7;
    logic [VAL_W-1:0] w_value;
    logic             w_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_seg <= SEG_OFF;
            r_dig <= 2'b00;
        end else begin
            r_seg <= bus.SEG;
            r_dig <= bus.DIG;
        end
    end

    assign w_code = seg7_decode(r_seg);

    seg7_digit_tracker #(.STABLE_CYCLES(STABLE_CYCLES)) u_units (
        .clock   (clock),
        .reset_n (reset_n),
        .i_own   (r_dig == 2'b01),
        .i_code  (w_code),
        .o_num   (w_num_u),
        .o_chg   (w_chg_u),
        .o_done  (w_done_u)
    );

    seg7_digit_tracker #(.STABLE_CYCLES(STABLE_CYCLES)) u_tens (
        .clock   (clock),
        .reset_n (reset_n),
        .i_own   (r_dig == 2'b10),
        .i_code  (w_code),
        .o_num   (w_num_t),
        .o_chg   (w_chg_t),
        .o_done  (w_done_t)
    );

    // Blank tens reads as a leading zero; blank units or any illegal digit is unrepresentable.
    assign w_units_ok = (w_num_u <= 5'd9);
    assign w_tens_ok  = (w_num_t <= 5'd9) || (w_num_t == NUM_OFF);
    assign w_tens7    = (w_num_t == NUM_OFF) ? 7'd0 : VAL_W'(w_num_t);
    assign w_value    = (w_units_ok && w_tens_ok) ? (w_tens7 * 7'd10 + VAL_W'(w_num_u)) : VALUE_BAD;
    assign w_valid    = w_done_u && w_done_t && w_units_ok && w_tens_ok;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_value  <= '0;
            r_valid  <= 1'b0;
            r_update <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_update <= 1'b0;
            if (w_chg_u || w_chg_t) begin
                r_value  <= w_value;
                r_valid  <= w_valid;
                r_update <= 1'b1;
            end
            if ((r_dig == 2'b11) || (w_num_u == NUM_ILLEGAL) || (w_num_t == NUM_ILLEGAL)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.NUM_UNITS = w_num_u;
    assign bus.NUM_TENS  = w_num_t;
    assign bus.VALUE     = r_value;
    assign bus.valid     = r_valid;
    assign bus.update    = r_update;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Directed bench for seg7_readback_decoder with STABLE_CYCLES=4.
module tb_seg7_readback_decoder;

    logic clock;
    logic reset_n;
    int   n_assert;
    int   n_fail;
    int   upd_cnt;

    seg7_readback_decoder_if bus ();

    seg7_readback_decoder #(.STABLE_CYCLES(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) if (bus.update === 1'b1) upd_cnt++;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Presents one sample and returns at the following falling edge.
    task automatic step(input logic [6:0] seg, input logic [1:0] dig);
        bus.SEG = seg;
        bus.DIG = dig;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(7'h7F, 2'b00);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_units"},  int'(bus.NUM_UNITS), 31);
        chk({tag, "_tens"},   int'(bus.NUM_TENS),  31);
        chk({tag, "_value"},  int'(bus.VALUE),     0);
        chk({tag, "_valid"},  int'(bus.valid),     0);
        chk({tag, "_update"}, int'(bus.update),    0);
        chk({tag, "_err"},    int'(bus.err),       0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        upd_cnt  = 0;
        reset_n  = 1'b0;
        bus.SEG  = 7'h7F;
        bus.DIG  = 2'b00;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Idle after reset: outputs hold reset values
        for (int i = 0; i < 20; i++) begin
            step(7'h7F, 2'b00);
            chk_reset_outputs("idle");
        end

        // Alternating scan: units 7, tens 2
        upd_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(7'b1111000, 2'b01);
            step(7'b0100100, 2'b10);
        end
        idle(3);
        chk("alt_units",  int'(bus.NUM_UNITS), 7);
        chk("alt_tens",   int'(bus.NUM_TENS),  2);
        chk("alt_value",  int'(bus.VALUE),     27);
        chk("alt_valid",  int'(bus.valid),     1);
        chk("alt_pulses", upd_cnt,             2);
        chk("alt_err",    int'(bus.err),       0);

        // Glitch: 3,3,3,8 then 3 until four consecutive
        upd_cnt = 0;
        for (int i = 0; i < 3; i++) step(7'b0110000, 2'b01);
        step(7'b0000000, 2'b01);
        for (int i = 0; i < 4; i++) step(7'b0110000, 2'b01);
        chk("glitch_hold", int'(bus.NUM_UNITS), 7);
        step(7'b0110000, 2'b01);
        chk("glitch_commit", int'(bus.NUM_UNITS), 3);
        idle(2);
        chk("glitch_value",  int'(bus.VALUE), 23);
        chk("glitch_pulses", upd_cnt,         1);

        // Units 5 then tens blank
        for (int i = 0; i < 5; i++) step(7'b0010010, 2'b01);
        idle(2);
        chk("u5_units", int'(bus.NUM_UNITS), 5);
        chk("u5_value", int'(bus.VALUE),     25);
        for (int i = 0; i < 5; i++) step(7'h7F, 2'b10);
        idle(2);
        chk("toff_tens",  int'(bus.NUM_TENS), 31);
        chk("toff_value", int'(bus.VALUE),    5);
        chk("toff_valid", int'(bus.valid),    1);
        chk("toff_err",   int'(bus.err),      0);

        // DIG=11 mid-track: sets err, count neither advances nor clears
        step(7'b0010000, 2'b01);
        step(7'b0010000, 2'b01);
        step(7'b0010000, 2'b11);
        step(7'b0010000, 2'b01);
        step(7'h7F,      2'b00);
        chk("d11_err",   int'(bus.err),       1);
        chk("d11_hold1", int'(bus.NUM_UNITS), 5);
        step(7'b0010000, 2'b01);
        chk("d11_hold2", int'(bus.NUM_UNITS), 5);
        step(7'h7F, 2'b00);
        chk("d11_commit", int'(bus.NUM_UNITS), 9);
        idle(2);
        chk("d11_value", int'(bus.VALUE), 9);

        // Asynchronous reset in the middle of tracking
        for (int i = 0; i < 3; i++) step(7'b0100100, 2'b01);
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs("async_rst");
        @(negedge clock);
        bus.SEG = 7'h7F;
        bus.DIG = 2'b00;
        reset_n = 1'b1;
        idle(2);
        chk_reset_outputs("post_rst");

        // Illegal pattern committed on units
        for (int i = 0; i < 5; i++) step(7'b1010101, 2'b01);
        idle(2);
        chk("ill_units", int'(bus.NUM_UNITS), 30);
        chk("ill_value", int'(bus.VALUE),     127);
        chk("ill_valid", int'(bus.valid),     0);
        chk("ill_err",   int'(bus.err),       1);
        idle(10);
        chk("ill_err_sticky", int'(bus.err), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
